// File: rtl/dpram_clr_if.sv
// Port bundle for the byte-enabled dual-port RAM with clear engine.
// The master side drives both ports and the clear request.
interface dpram_clr_if #(
   parameter int DW = 32,
   parameter int AW = 6
) ();
   logic [DW-1:0]   data_a;
   logic [DW-1:0]   data_b;
   logic [AW-1:0]   addr_a;
   logic [AW-1:0]   addr_b;
   logic            we_a;
   logic            we_b;
   logic [DW/8-1:0] be_a;
   logic [DW/8-1:0] be_b;
   logic [DW-1:0]   q_a;
   logic [DW-1:0]   q_b;
   logic            clr_req;
   logic            clr_busy;
   logic            clr_done;

   modport master (
      output data_a, data_b, addr_a, addr_b,
      output we_a, we_b, be_a, be_b, clr_req,
      input  q_a, q_b, clr_busy, clr_done
   );

   modport slave (
      input  data_a, data_b, addr_a, addr_b,
      input  we_a, we_b, be_a, be_b, clr_req,
      output q_a, q_b, clr_busy, clr_done
   );
endinterface

// File: rtl/dpram_clr.sv
// Dual-port byte-enabled RAM with a sequential full-memory clear engine.
// Port A wins on overlapping bytes; cross-port reads see the old word.
module dpram_clr #(
   parameter int            DW       = 32,
   parameter int            AW       = 6,
   parameter int            RDW_MODE = 0,
   parameter int            OUT_REG  = 0,
   parameter logic [DW-1:0] CLR_VAL  = '0
) (
   input logic        clk,
   input logic        reset,
   dpram_clr_if.slave bus
);
   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << AW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    st;
   logic [AW-1:0] cnt;
   logic [DW-1:0] mem [DEPTH];

   logic          clearing;
   logic          wr_a, wr_b, same;
   logic [DW-1:0] ma, mb;
   logic [DW-1:0] old_a, old_b;
   logic [DW-1:0] new_a, new_b, new_ab;
   logic [DW-1:0] rd_a, rd_b;
   logic [DW-1:0] q1a, q1b;

   assign clearing = (st == S_CLEAR);

   always_comb begin
      ma = '0;
      mb = '0;
      for (int i = 0; i < NB; i++) begin
         ma[8*i +: 8] = {8{bus.be_a[i]}};
         mb[8*i +: 8] = {8{bus.be_b[i]}};
      end
   end

   assign wr_a   = bus.we_a && !clearing;
   assign wr_b   = bus.we_b && !clearing;
   assign same   = (bus.addr_a == bus.addr_b);
   assign old_a  = mem[bus.addr_a];
   assign old_b  = mem[bus.addr_b];
   assign new_a  = (old_a & ~ma) | (bus.data_a & ma);
   assign new_b  = (old_b & ~mb) | (bus.data_b & mb);
   // Same-address double write folds both merges into one word.
   assign new_ab = (old_a & ~(ma | mb))
                 | (bus.data_a & ma)
                 | (bus.data_b & mb & ~ma);

   assign rd_a = (RDW_MODE == 0 && bus.we_a) ? new_a : old_a;
   assign rd_b = (RDW_MODE == 0 && bus.we_b) ? new_b : old_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         st  <= S_IDLE;
         cnt <= '0;
      end else begin
         unique case (st)
            S_IDLE: begin
               if (bus.clr_req) begin
                  st  <= S_CLEAR;
                  cnt <= '0;
               end
            end
            S_CLEAR: begin
               if (cnt == '1) st <= S_DONE;
               else cnt <= cnt + AW'(1);
            end
            S_DONE:  st <= S_IDLE;
            default: st <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clearing) begin
            mem[cnt] <= CLR_VAL;
         end else begin
            if (wr_a)
               mem[bus.addr_a] <= (same && wr_b) ? new_ab : new_a;
            if (wr_b && !(same && wr_a))
               mem[bus.addr_b] <= new_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q1a <= '0;
         q1b <= '0;
      end else if (!clearing) begin
         q1a <= rd_a;
         q1b <= rd_b;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DW-1:0] q2a, q2b;
         always_ff @(posedge clk) begin
            if (reset) begin
               q2a <= '0;
               q2b <= '0;
            end else if (!clearing) begin
               q2a <= q1a;
               q2b <= q1b;
            end
         end
         assign bus.q_a = q2a;
         assign bus.q_b = q2b;
      end else begin : g_noreg
         assign bus.q_a = q1a;
         assign bus.q_b = q1b;
      end
   endgenerate

   assign bus.clr_busy = (st == S_CLEAR);
   assign bus.clr_done = (st == S_DONE);
endmodule
